// File: rtl/add_vec_writer_pkg.sv
// Shared types for the adder test-vector writer: FSM states and field codes.
package add_vec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EMIT_A,
      EMIT_B,
      EMIT_C,
      FIN
   } state_t;

   localparam logic [1:0] FLD_A = 2'd0;
   localparam logic [1:0] FLD_B = 2'd1;
   localparam logic [1:0] FLD_C = 2'd2;

endpackage

// File: rtl/add_vec_writer_ctr.sv
// Vector index counter with clear, increment enable and terminal-count flag.
module add_vec_ctr #(
   parameter int N = 15,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [IW-1:0] idx,
   output logic          last
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         idx <= '0;
      else if (clr)
         idx <= '0;
      else if (inc)
         idx <= idx + 1'b1;
   end

   assign last = (idx == IW'(N - 1));

endmodule

// File: rtl/add_vec_writer.sv
// Streams a, b, a+b test vectors to a memory image over valid/ready.
// Optional running checksum output when ADD_VEC_CKSUM_EN is defined.
module add_vec_writer
   import add_vec_pkg::*;
#(
   parameter int W       = 4,
   parameter int NUM_VEC = 15,
   parameter int STEP    = 1,
   localparam int AW = $clog2(3 * NUM_VEC),
   localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          ready,
   output logic          valid,
   output logic [W:0]    word,
   output logic [AW-1:0] addr,
   output logic          busy,
`ifdef ADD_VEC_CKSUM_EN
   output logic [15:0]   cksum,
`endif
   output logic          done
);

   localparam logic [W-1:0] STEPW = W'(STEP);

   state_t        state;
   state_t        nxt;
   logic [IW-1:0] idx;
   logic          last;
   logic          inc;
   logic          clr;
   logic [1:0]    fld;
   logic          xfer;
   logic [W-1:0]  a;
   logic [W-1:0]  b;

   add_vec_ctr #(.N(NUM_VEC)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc),
      .idx   (idx),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt   = state;
      valid = 1'b0;
      fld   = FLD_A;
      inc   = 1'b0;
      clr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nxt = EMIT_A;
               clr = 1'b1;
            end
         end
         EMIT_A: begin
            valid = 1'b1;
            if (ready) nxt = EMIT_B;
         end
         EMIT_B: begin
            valid = 1'b1;
            fld   = FLD_B;
            if (ready) nxt = EMIT_C;
         end
         EMIT_C: begin
            valid = 1'b1;
            fld   = FLD_C;
            if (ready) begin
               if (last) begin
                  nxt = FIN;
               end else begin
                  nxt = EMIT_A;
                  inc = 1'b1;
               end
            end
         end
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign xfer = valid & ready;
   assign busy = (state != IDLE);
   assign done = (state == FIN);

   // low W bits of i*STEP depend only on the low W bits of each factor
   assign a = W'(idx);
   assign b = a * STEPW;

   always_comb begin
      word = '0;
      addr = '0;
      if (valid) begin
         addr = AW'(idx) * AW'(3) + AW'(fld);
         unique case (fld)
            FLD_A:   word = {1'b0, a};
            FLD_B:   word = {1'b0, b};
            default: word = {1'b0, a} + {1'b0, b};
         endcase
      end
   end

`ifdef ADD_VEC_CKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         cksum <= '0;
      else if (state == IDLE && start)
         cksum <= '0;
      else if (xfer)
         cksum <= cksum + 16'(word);
   end
`endif

endmodule
